// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and execute-side training/resolution signals of the branch predictor.
// Latency: prediction and resolution are combinational; training is visible one cycle after its edge.
// Backpressure: none; the predictor accepts every update presented with upd_valid.
interface branch_predictor_if;
  // fetch-stage lookup
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  // execute-stage resolution / training
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic [2:0]  upd_funct3;
  logic        upd_eq;
  logic        upd_lt;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        resolved_taken;
  logic        mispredict;
  // performance counters
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output pred_pc, upd_valid, upd_pc, upd_target, upd_funct3,
           upd_eq, upd_lt, upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, resolved_taken, mispredict,
           branch_count, mispredict_count
  );

  modport slave (
    input  pred_pc, upd_valid, upd_pc, upd_target, upd_funct3,
           upd_eq, upd_lt, upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, resolved_taken, mispredict,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit BHT + BTB with branch resolution, mispredict flag and perf counters.
// Latency: 0-cycle predict and resolve; table writes visible to lookups the cycle after the edge.
// Backpressure: none; every legal upd_valid branch is trained and counted in the cycle it is presented.
module branch_predictor #(
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave bp
);

  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam int TAG_LO     = INDEX_BITS + 2;
  localparam int TAG_HI     = INDEX_BITS + TAG_BITS + 1;

  // Only valid bits are reset; tag/ctr/target are qualified by valid.
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_mem [ENTRIES];
  logic [1:0]          ctr_mem [ENTRIES];
  logic [31:0]         tgt_mem [ENTRIES];

  logic [31:0] branch_cnt_q;
  logic [31:0] mispredict_cnt_q;

  logic [INDEX_BITS-1:0] p_idx;
  logic [TAG_BITS-1:0]   p_tag;
  logic                  p_hit;
  logic                  p_taken;

  logic [INDEX_BITS-1:0] u_idx;
  logic [TAG_BITS-1:0]   u_tag;
  logic                  u_hit;
  logic [1:0]            u_ctr;
  logic [1:0]            u_ctr_next;
  logic                  legal;
  logic                  taken_raw;
  logic                  u_taken;
  logic                  u_mispredict;
  logic                  do_update;

  // PC bits that neither index nor tag the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.pred_pc[1:0], bp.pred_pc[31:TAG_HI+1],
                            bp.upd_pc[1:0], bp.upd_pc[31:TAG_HI+1]};

  assign p_idx = bp.pred_pc[INDEX_BITS+1:2];
  assign p_tag = bp.pred_pc[TAG_HI:TAG_LO];
  assign u_idx = bp.upd_pc[INDEX_BITS+1:2];
  assign u_tag = bp.upd_pc[TAG_HI:TAG_LO];

  // Fetch lookup: reads the pre-write table, so a same-cycle update is not forwarded.
  always_comb begin
    p_hit           = valid_q[p_idx] && (tag_mem[p_idx] == p_tag);
    p_taken         = !rst && p_hit && ctr_mem[p_idx][1];
    bp.pred_taken   = p_taken;
    bp.pred_target  = p_taken ? tgt_mem[p_idx] : 32'h0;
  end

  // Branch condition decode; funct3 010/011 are not conditional branches.
  always_comb begin
    legal     = 1'b1;
    taken_raw = 1'b0;
    case (bp.upd_funct3)
      3'b000:         taken_raw = bp.upd_eq;
      3'b001:         taken_raw = !bp.upd_eq;
      3'b100, 3'b110: taken_raw = bp.upd_lt;
      3'b101, 3'b111: taken_raw = !bp.upd_lt;
      default:        legal     = 1'b0;
    endcase
  end

  // Actual outcome, mispredict detection and saturating counter step.
  always_comb begin
    u_taken      = bp.upd_valid && legal && taken_raw;
    do_update    = bp.upd_valid && legal && !rst;
    u_mispredict = do_update &&
                   ((u_taken != bp.upd_pred_taken) ||
                    (u_taken && (bp.upd_pred_target != bp.upd_target)));
    u_hit        = valid_q[u_idx] && (tag_mem[u_idx] == u_tag);
    u_ctr        = ctr_mem[u_idx];
    if (u_taken) begin
      u_ctr_next = (u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'd1;
    end else begin
      u_ctr_next = (u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'd1;
    end
  end

  assign bp.resolved_taken = u_taken;
  assign bp.mispredict     = u_mispredict;

  // Valid bits: cleared on reset, set only by a taken miss (not-taken misses never allocate).
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (do_update && !u_hit && u_taken) begin
      valid_q[u_idx] <= 1'b1;
    end
  end

  // Entry payload: train on hit, allocate/replace on taken miss.
  always_ff @(posedge clk) begin
    if (do_update) begin
      if (u_hit) begin
        ctr_mem[u_idx] <= u_ctr_next;
        if (u_taken) begin
          tgt_mem[u_idx] <= bp.upd_target;
        end
      end else if (u_taken) begin
        tag_mem[u_idx] <= u_tag;
        ctr_mem[u_idx] <= 2'b10;
        tgt_mem[u_idx] <= bp.upd_target;
      end
    end
  end

  // Performance counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q     <= 32'h0;
      mispredict_cnt_q <= 32'h0;
    end else if (do_update) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (u_mispredict) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

  assign bp.branch_count     = branch_cnt_q;
  assign bp.mispredict_count = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
// Latency: inputs driven 1ns after posedge, outputs sampled before the next edge.
// Backpressure: none exercised; the design has no stall path.
module tb_branch_predictor;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  branch_predictor_if bp ();

  branch_predictor #(.ENTRIES(64), .TAG_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp.upd_valid       = 1'b0;
    bp.upd_pc          = 32'h0;
    bp.upd_target      = 32'h0;
    bp.upd_funct3      = 3'b000;
    bp.upd_eq          = 1'b0;
    bp.upd_lt          = 1'b0;
    bp.upd_pred_taken  = 1'b0;
    bp.upd_pred_target = 32'h0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] f3,
                         input logic eq, input logic lt, input logic ptk, input logic [31:0] ptgt);
    bp.upd_valid       = 1'b1;
    bp.upd_pc          = pc;
    bp.upd_target      = tgt;
    bp.upd_funct3      = f3;
    bp.upd_eq          = eq;
    bp.upd_lt          = lt;
    bp.upd_pred_taken  = ptk;
    bp.upd_pred_target = ptgt;
  endtask

  // One update over one clock edge, then return to idle.
  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] f3,
                       input logic eq, input logic lt);
    set_upd(pc, tgt, f3, eq, lt, 1'b0, 32'h0);
    step();
    idle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    bp.pred_pc = 32'h100;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h0) begin
      failures++;
      $display("FAIL reset_pred: taken=%0b target=%h expected 0/00000000", bp.pred_taken, bp.pred_target);
    end
    checks++;
    if (bp.branch_count !== 32'h0 || bp.mispredict_count !== 32'h0) begin
      failures++;
      $display("FAIL reset_counts: branch=%0d mispredict=%0d expected 0/0", bp.branch_count, bp.mispredict_count);
    end
  endtask

  task automatic test_training();
    do_reset();
    bp.pred_pc = 32'h100;
    train(32'h100, 32'h80, 3'b000, 1'b1, 1'b0);   // alloc ctr=10
    checks++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h80) begin
      failures++;
      $display("FAIL train_alloc: taken=%0b target=%h expected 1/00000080", bp.pred_taken, bp.pred_target);
    end
    train(32'h100, 32'h80, 3'b000, 1'b1, 1'b0);   // 11
    train(32'h100, 32'h80, 3'b000, 1'b1, 1'b0);   // 11 (saturated)
    checks++;
    if (bp.pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL train_sat_hi: taken=%0b expected 1", bp.pred_taken);
    end
    train(32'h100, 32'h80, 3'b000, 1'b0, 1'b0);   // 10
    checks++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h80) begin
      failures++;
      $display("FAIL train_hyst: taken=%0b target=%h expected 1/00000080", bp.pred_taken, bp.pred_target);
    end
    train(32'h100, 32'h80, 3'b000, 1'b0, 1'b0);   // 01
    checks++;
    if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h0) begin
      failures++;
      $display("FAIL train_flip: taken=%0b target=%h expected 0/00000000", bp.pred_taken, bp.pred_target);
    end
    for (int i = 0; i < 3; i++) train(32'h100, 32'h80, 3'b000, 1'b0, 1'b0);   // 00
    checks++;
    if (bp.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL train_sat_lo: taken=%0b expected 0", bp.pred_taken);
    end
    train(32'h100, 32'h80, 3'b000, 1'b1, 1'b0);   // 01: proves ctr floored at 00
    checks++;
    if (bp.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL train_floor_inc1: taken=%0b expected 0", bp.pred_taken);
    end
    train(32'h100, 32'h84, 3'b000, 1'b1, 1'b0);   // 10, target refreshed
    checks++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h84) begin
      failures++;
      $display("FAIL train_floor_inc2: taken=%0b target=%h expected 1/00000084", bp.pred_taken, bp.pred_target);
    end
  endtask

  task automatic test_decode();
    logic [2:0] f3_tab [6];
    logic       eq_tab [6];
    logic       lt_tab [6];
    logic       exp_tab[6];
    f3_tab = '{3'b111, 3'b100, 3'b001, 3'b101, 3'b000, 3'b110};
    eq_tab = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0};
    lt_tab = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1};
    exp_tab = '{1'b1,  1'b1,   1'b0,   1'b0,   1'b0,   1'b1};
    do_reset();
    bp.pred_pc = 32'h300;
    for (int i = 0; i < 6; i++) begin
      step();
      set_upd(32'h300, 32'h500, f3_tab[i], eq_tab[i], lt_tab[i], 1'b0, 32'h0);
      #1;
      checks++;
      if (bp.resolved_taken !== exp_tab[i]) begin
        failures++;
        $display("FAIL decode_f3_%b: resolved_taken=%0b expected %0b", f3_tab[i], bp.resolved_taken, exp_tab[i]);
      end
      idle();
    end
    // upd_valid low gates the outcome
    step();
    set_upd(32'h300, 32'h500, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
    bp.upd_valid = 1'b0;
    #1;
    checks++;
    if (bp.resolved_taken !== 1'b0 || bp.mispredict !== 1'b0) begin
      failures++;
      $display("FAIL decode_novalid: resolved=%0b mispredict=%0b expected 0/0", bp.resolved_taken, bp.mispredict);
    end
    // illegal funct3 010 then 011, each across a clock edge
    step();
    set_upd(32'h300, 32'h500, 3'b010, 1'b1, 1'b1, 1'b1, 32'h500);
    #1;
    checks++;
    if (bp.resolved_taken !== 1'b0 || bp.mispredict !== 1'b0) begin
      failures++;
      $display("FAIL decode_illegal_comb: resolved=%0b mispredict=%0b expected 0/0", bp.resolved_taken, bp.mispredict);
    end
    step();
    set_upd(32'h300, 32'h500, 3'b011, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    idle();
    #1;
    checks++;
    if (bp.branch_count !== 32'h0 || bp.mispredict_count !== 32'h0 || bp.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL decode_illegal_state: branch=%0d mispredict=%0d pred_taken=%0b expected 0/0/0",
               bp.branch_count, bp.mispredict_count, bp.pred_taken);
    end
  endtask

  task automatic test_aliasing();
    do_reset();
    train(32'h100, 32'h80, 3'b000, 1'b1, 1'b0);
    bp.pred_pc = 32'h1100;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL alias_tag_miss: taken=%0b expected 0", bp.pred_taken);
    end
    train(32'h1100, 32'h40, 3'b000, 1'b0, 1'b0);   // not-taken miss: no allocation
    bp.pred_pc = 32'h100;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h80) begin
      failures++;
      $display("FAIL alias_nt_keep: taken=%0b target=%h expected 1/00000080", bp.pred_taken, bp.pred_target);
    end
    train(32'h1100, 32'h40, 3'b000, 1'b1, 1'b0);   // taken miss: replace
    bp.pred_pc = 32'h1100;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h40) begin
      failures++;
      $display("FAIL alias_replace: taken=%0b target=%h expected 1/00000040", bp.pred_taken, bp.pred_target);
    end
    bp.pred_pc = 32'h100;
    #1;
    checks++;
    if (bp.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL alias_evicted: taken=%0b expected 0", bp.pred_taken);
    end
  endtask

  task automatic test_mispredict_counters();
    do_reset();
    // predicted not-taken, actually taken
    set_upd(32'h400, 32'h80, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (bp.mispredict !== 1'b1) begin
      failures++;
      $display("FAIL mp_dir: mispredict=%0b expected 1", bp.mispredict);
    end
    step();
    checks++;
    if (bp.branch_count !== 32'd1 || bp.mispredict_count !== 32'd1) begin
      failures++;
      $display("FAIL mp_dir_counts: branch=%0d mispredict=%0d expected 1/1", bp.branch_count, bp.mispredict_count);
    end
    // direction right, target wrong
    set_upd(32'h400, 32'h84, 3'b000, 1'b1, 1'b0, 1'b1, 32'h80);
    #1;
    checks++;
    if (bp.mispredict !== 1'b1) begin
      failures++;
      $display("FAIL mp_target: mispredict=%0b expected 1", bp.mispredict);
    end
    step();
    // correct not-taken
    set_upd(32'h400, 32'h84, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (bp.mispredict !== 1'b0) begin
      failures++;
      $display("FAIL mp_correct_nt: mispredict=%0b expected 0", bp.mispredict);
    end
    step();
    // correct taken, matching target
    set_upd(32'h400, 32'h84, 3'b000, 1'b1, 1'b0, 1'b1, 32'h84);
    #1;
    checks++;
    if (bp.mispredict !== 1'b0) begin
      failures++;
      $display("FAIL mp_correct_t: mispredict=%0b expected 0", bp.mispredict);
    end
    step();
    // predicted taken, actually not taken
    set_upd(32'h400, 32'h84, 3'b001, 1'b1, 1'b0, 1'b1, 32'h84);
    #1;
    checks++;
    if (bp.mispredict !== 1'b1) begin
      failures++;
      $display("FAIL mp_false_taken: mispredict=%0b expected 1", bp.mispredict);
    end
    step();
    idle();
    #1;
    checks++;
    if (bp.branch_count !== 32'd5 || bp.mispredict_count !== 32'd3) begin
      failures++;
      $display("FAIL mp_counts: branch=%0d mispredict=%0d expected 5/3", bp.branch_count, bp.mispredict_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.branch_cnt_q     = 32'hFFFF_FFFF;
    force dut.mispredict_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_q;
    release dut.mispredict_cnt_q;
    #1;
    set_upd(32'h500, 32'h80, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);   // mispredicting branch
    step();
    idle();
    #1;
    checks++;
    if (bp.branch_count !== 32'h0 || bp.mispredict_count !== 32'h0) begin
      failures++;
      $display("FAIL wrap: branch=%h mispredict=%h expected 00000000/00000000", bp.branch_count, bp.mispredict_count);
    end
    train(32'h500, 32'h80, 3'b000, 1'b0, 1'b0);   // correct not-taken
    checks++;
    if (bp.branch_count !== 32'd1 || bp.mispredict_count !== 32'd0) begin
      failures++;
      $display("FAIL wrap_after: branch=%0d mispredict=%0d expected 1/0", bp.branch_count, bp.mispredict_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bp.pred_pc = 32'h200;
    set_upd(32'h200, 32'h90, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (bp.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL simul_same_cycle: taken=%0b expected 0", bp.pred_taken);
    end
    step();
    idle();
    #1;
    checks++;
    if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h90) begin
      failures++;
      $display("FAIL simul_next_cycle: taken=%0b target=%h expected 1/00000090", bp.pred_taken, bp.pred_target);
    end
    // reset wins over a concurrent update
    rst = 1'b1;
    set_upd(32'h200, 32'h90, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (bp.mispredict !== 1'b0 || bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h0) begin
      failures++;
      $display("FAIL rst_gate: mispredict=%0b taken=%0b target=%h expected 0/0/00000000",
               bp.mispredict, bp.pred_taken, bp.pred_target);
    end
    step();
    rst = 1'b0;
    idle();
    #1;
    checks++;
    if (bp.pred_taken !== 1'b0 || bp.branch_count !== 32'h0 || bp.mispredict_count !== 32'h0) begin
      failures++;
      $display("FAIL rst_vs_upd: taken=%0b branch=%0d mispredict=%0d expected 0/0/0",
               bp.pred_taken, bp.branch_count, bp.mispredict_count);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    bp.pred_pc = 32'h0;
    idle();
    test_reset();
    test_training();
    test_decode();
    test_aliasing();
    test_mispredict_counters();
    test_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
